// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage requester for the 32-bit multi-cycle divider.
// Accepts a DIV/DIVU request, holds start and operands until the divider
// reports ready, and returns HI/LO with a one-cycle write strobe. A pipeline
// flush or a watchdog expiry annuls the divide. After an annul, start is kept
// low for DRAIN_CYCLES cycles so the divider can return to its free state.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   inst_valid_i, signed_i   divide request in EX and its signedness
//   op1_i, op2_i             dividend / divisor
//   flush_i                  kills the in-flight divide
//   div_result_i/div_ready_i {remainder, quotient} and valid from the divider
//   div_start_o/div_annul_o  divider handshake
//   div_signed_o, div_opdata1_o, div_opdata2_o   latched request
//   stall_o                  pipeline hold (combinational)
//   hi_o, lo_o, whilo_o      remainder, quotient, write strobe
//   dbz_o                    divide-by-zero, qualifies whilo_o
//   err_o                    sticky watchdog error
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT      = 40,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic        signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        dbz_o,
    output logic        err_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DR_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic              annul_q, annul_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              whilo_q, whilo_d;
    logic              dbz_q, dbz_d;
    logic              dbz_flag_q, dbz_flag_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DR_W-1:0]   dr_q, dr_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            annul_q    <= 1'b0;
            signed_q   <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            whilo_q    <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_flag_q <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
            dr_q       <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            annul_q    <= annul_d;
            signed_q   <= signed_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            whilo_q    <= whilo_d;
            dbz_q      <= dbz_d;
            dbz_flag_q <= dbz_flag_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            dr_q       <= dr_d;
        end
    end

    // Next-state, next-output and stall logic
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        annul_d    = 1'b0;
        whilo_d    = 1'b0;
        dbz_d      = 1'b0;
        signed_d   = signed_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_flag_d = dbz_flag_q;
        err_d      = err_q;
        wd_d       = wd_q;
        dr_d       = dr_q;
        stall_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_o = inst_valid_i & ~flush_i;
                if (inst_valid_i && !flush_i) begin
                    signed_d   = signed_i;
                    op1_d      = op1_i;
                    op2_d      = op2_i;
                    dbz_flag_d = (op2_i == '0);
                    start_d    = 1'b1;
                    wd_d       = '0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                // Flush beats ready beats watchdog; operands stay frozen.
                stall_o = ~div_ready_i | flush_i;
                start_d = 1'b1;
                if (flush_i) begin
                    start_d = 1'b0;
                    annul_d = 1'b1;
                    dr_d    = '0;
                    state_d = S_DRAIN;
                end else if (div_ready_i) begin
                    hi_d    = div_result_i[63:32];
                    lo_d    = div_result_i[31:0];
                    whilo_d = 1'b1;
                    dbz_d   = dbz_flag_q;
                    start_d = 1'b0;
                    state_d = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    annul_d = 1'b1;
                    start_d = 1'b0;
                    dr_d    = '0;
                    state_d = S_DRAIN;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            S_DONE: begin
                // Strobe cycle; the instruction still in EX is the one completing.
                state_d = S_IDLE;
            end

            S_DRAIN: begin
                // Requests wait here until the divider is free again.
                stall_o = inst_valid_i;
                if (dr_q == DR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    dr_d = dr_q + DR_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!rst) begin
            stall_o = 1'b0;
        end
    end

    assign div_start_o   = start_q;
    assign div_annul_o   = annul_q;
    assign div_signed_o  = signed_q;
    assign div_opdata1_o = op1_q;
    assign div_opdata2_o = op2_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign whilo_o       = whilo_q;
    assign dbz_o         = dbz_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a latency-35 divider stand-in, a per-cycle
// transaction-level reference, and directed scenarios with literal results.
`timescale 1ns/1ps
module tb_div_issue_ctrl;

    localparam int unsigned TIMEOUT      = 40;
    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned DIV_LAT      = 35;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic        signed_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        flush_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        dbz_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    div_issue_ctrl #(.TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid_i (inst_valid_i),
        .signed_i     (signed_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .flush_i      (flush_i),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .stall_o      (stall_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .whilo_o      (whilo_o),
        .dbz_o        (dbz_o),
        .err_o        (err_o)
    );

    // {remainder, quotient}, zero for a zero divisor
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Divider stand-in: ready once start has been held DIV_LAT cycles
    bit          stuck = 1'b0;
    int unsigned dcnt  = 0;
    always @(posedge clk) dcnt <= div_start_o ? dcnt + 1 : 0;
    assign div_ready_i = div_start_o && (dcnt == DIV_LAT) && !stuck;
    always_comb div_result_i = ref_div(div_signed_o, div_opdata1_o, div_opdata2_o);

    // Reference: what the controller must present in the following cycle
    bit        m_busy, m_done;
    int        m_drain_left, m_wait;
    bit        e_start, e_annul, e_signed, e_whilo, e_dbz, e_err;
    bit [31:0] e_op1, e_op2, e_hi, e_lo;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_drain_left = 0; m_wait = 0;
            e_start = 0; e_annul = 0; e_signed = 0; e_whilo = 0; e_dbz = 0; e_err = 0;
            e_op1 = 0; e_op2 = 0; e_hi = 0; e_lo = 0;
        end else begin
            e_annul = 0; e_whilo = 0; e_dbz = 0;
            if (m_busy) begin
                if (flush_i) begin
                    m_busy = 0; e_start = 0; e_annul = 1; m_drain_left = DRAIN_CYCLES;
                end else if (div_ready_i) begin
                    {e_hi, e_lo} = ref_div(e_signed, e_op1, e_op2);
                    e_whilo = 1; e_dbz = (e_op2 == 32'd0);
                    m_busy = 0; m_done = 1; e_start = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        e_err = 1; e_annul = 1; e_start = 0;
                        m_busy = 0; m_drain_left = DRAIN_CYCLES;
                    end
                end
            end else if (m_done) begin
                m_done = 0;
            end else if (m_drain_left > 0) begin
                m_drain_left--;
            end else if (inst_valid_i && !flush_i) begin
                e_signed = signed_i; e_op1 = op1_i; e_op2 = op2_i;
                m_busy = 1; m_wait = 0; e_start = 1;
            end
        end
    end

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        bit es;
        if (cmp_en) begin
            if (!rst)                  es = 0;
            else if (m_busy)           es = !div_ready_i || flush_i;
            else if (m_done)           es = 0;
            else if (m_drain_left > 0) es = inst_valid_i;
            else                       es = inst_valid_i && !flush_i;
            chk("stall", stall_o, es);
            chk("start", div_start_o, e_start);
            chk("annul", div_annul_o, e_annul);
            chk("signed", div_signed_o, e_signed);
            chk("opdata1", div_opdata1_o, e_op1);
            chk("opdata2", div_opdata2_o, e_op2);
            chk("hi", hi_o, e_hi);
            chk("lo", lo_o, e_lo);
            chk("whilo", whilo_o, e_whilo);
            chk("dbz", dbz_o, e_dbz);
            chk("err", err_o, e_err);
        end
    end

    // Issue one divide, hold valid until the strobe; operand inputs are
    // scrambled once the divide is under way to prove the latch holds.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int stall_cnt, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dbz);
        bit got = 0;
        bit scr = 0;
        inst_valid_i = 1; signed_i = s; op1_i = a; op2_i = b;
        stall_cnt = 0; hi = 0; lo = 0; dbz = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (div_start_o) scr = 1;
            if (whilo_o) begin got = 1; hi = hi_o; lo = lo_o; dbz = dbz_o; end
            @(posedge clk); #1;
            if (scr) begin op1_i = ~a; op2_i = b ^ 32'h5A5A_0001; end
        end
        inst_valid_i = 0;
        chk("div_completed", 64'(got), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not end, expected finish by 100000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        int sc, n, rise, fl_cyc, annul_cnt, whilo_early, start_cnt;
        logic [31:0] hi, lo;
        logic dbz;
        bit seen;

        rst = 0; inst_valid_i = 0; signed_i = 0; op1_i = 0; op2_i = 0; flush_i = 0;

        // Reset: outputs zero, stall forced low even with a request present
        @(posedge clk); #1;
        cmp_en = 1;
        inst_valid_i = 1; op1_i = 32'd11; op2_i = 32'd3;
        @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_start", div_start_o, 0);
        chk("rst_err", err_o, 0);
        @(posedge clk); #1;
        rst = 1; inst_valid_i = 0;
        @(posedge clk); #1;

        // DIVU 100/7
        do_div(0, 32'd100, 32'd7, sc, hi, lo, dbz);
        chk("t1_stall_cycles", 64'(sc), 64'd36);
        chk("t1_lo", lo, 32'd14);
        chk("t1_hi", hi, 32'd2);
        chk("t1_dbz", dbz, 0);

        // DIV -7/2
        do_div(1, 32'hFFFF_FFF9, 32'd2, sc, hi, lo, dbz);
        chk("t2_lo", lo, 32'hFFFF_FFFD);
        chk("t2_hi", hi, 32'hFFFF_FFFF);
        chk("t2_opdata1", div_opdata1_o, 32'hFFFF_FFF9);
        chk("t2_opdata2", div_opdata2_o, 32'd2);

        // DIVU 5/0
        do_div(0, 32'd5, 32'd0, sc, hi, lo, dbz);
        chk("t3_dbz", dbz, 1);
        chk("t3_hi", hi, 0);
        chk("t3_lo", lo, 0);

        // Flush 10 cycles into WAIT, then an immediate new request 77/5
        inst_valid_i = 1; signed_i = 0; op1_i = 32'd1000; op2_i = 32'd3;
        n = 0;
        for (int i = 0; i < 50 && n < 10; i++) begin
            @(negedge clk);
            if (div_start_o) n++;
            @(posedge clk); #1;
        end
        flush_i = 1; inst_valid_i = 0; fl_cyc = cyc_cnt;
        @(negedge clk);
        @(posedge clk); #1;
        flush_i = 0; inst_valid_i = 1; op1_i = 32'd77; op2_i = 32'd5;
        annul_cnt = 0; whilo_early = 0; rise = -1; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (div_annul_o) annul_cnt++;
            if (div_start_o && rise < 0) rise = cyc_cnt;
            if (whilo_o && rise < 0) whilo_early++;
            if (whilo_o) begin seen = 1; hi = hi_o; lo = lo_o; end
            @(posedge clk); #1;
        end
        inst_valid_i = 0;
        chk("t4_annul_pulses", 64'(annul_cnt), 64'd1);
        chk("t4_no_write", 64'(whilo_early), 64'd0);
        chk("t4_restart_gap_ge3", 64'((rise - fl_cyc) >= 3), 64'd1);
        chk("t4_next_done", 64'(seen), 64'd1);
        chk("t4_lo", lo, 32'd15);
        chk("t4_hi", hi, 32'd2);

        // Divider never ready: watchdog abort, then a normal divide
        stuck = 1; inst_valid_i = 1; signed_i = 0; op1_i = 32'd9; op2_i = 32'd3;
        start_cnt = 0; annul_cnt = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (div_start_o) start_cnt++;
            if (div_annul_o) annul_cnt++;
            if (err_o) seen = 1;
            @(posedge clk); #1;
        end
        inst_valid_i = 0; stuck = 0;
        chk("t5_err_seen", 64'(seen), 64'd1);
        chk("t5_wait_cycles", 64'(start_cnt), 64'd40);
        chk("t5_annul_pulses", 64'(annul_cnt), 64'd1);
        do_div(0, 32'd9, 32'd3, sc, hi, lo, dbz);
        chk("t5_after_lo", lo, 32'd3);
        chk("t5_after_hi", hi, 32'd0);
        chk("t5_err_sticky", err_o, 1);

        // Back-to-back divides, then reset in the middle of a third
        do_div(0, 32'd1000, 32'd10, sc, hi, lo, dbz);
        chk("t6a_lo", lo, 32'd100);
        chk("t6a_hi", hi, 32'd0);
        do_div(1, 32'hFFFF_FF9C, 32'd7, sc, hi, lo, dbz);
        chk("t6b_lo", lo, 32'hFFFF_FFF2);
        chk("t6b_hi", hi, 32'hFFFF_FFFE);
        inst_valid_i = 1; signed_i = 0; op1_i = 32'd50; op2_i = 32'd5;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        rst = 0; inst_valid_i = 0;
        @(negedge clk);
        chk("t6_rst_stall", stall_o, 0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("t6_rst_start", div_start_o, 0);
        chk("t6_rst_annul", div_annul_o, 0);
        chk("t6_rst_signed", div_signed_o, 0);
        chk("t6_rst_op1", div_opdata1_o, 0);
        chk("t6_rst_op2", div_opdata2_o, 0);
        chk("t6_rst_hi", hi_o, 0);
        chk("t6_rst_lo", lo_o, 0);
        chk("t6_rst_whilo", whilo_o, 0);
        chk("t6_rst_dbz", dbz_o, 0);
        chk("t6_rst_err", err_o, 0);
        n = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (whilo_o) n++;
        end
        chk("t6_third_aborted", 64'(n), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage initiator for the 32-bit multi-cycle divider; the requester side of its start/annul/ready handshake.
- Captures a DIV/DIVU request, launches the divider, and stalls the pipeline until ready.
- Returns HI (remainder) / LO (quotient) with a one-cycle write strobe.
- Handles pipeline flush by annulling the divide and draining the divider, and guards against a hung divider with a watchdog.

Parameters:
- TIMEOUT, 40, maximum cycles in WAIT before abort; must exceed divider latency of 35.
- DRAIN_CYCLES, 2, cycles start_o is held low after an abort so the divider reaches its free state.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- inst_valid_i  in  1  divide instruction present in EX
- signed_i  in  1  1=DIV, 0=DIVU
- op1_i  in  32  dividend
- op2_i  in  32  divisor
- flush_i  in  1  pipeline flush, kills the in-flight divide
- div_result_i  in  64  {remainder, quotient} from divider
- div_ready_i  in  1  divider result valid
- div_start_o  out  1  divider start request
- div_annul_o  out  1  divider annul pulse
- div_signed_o  out  1  latched signedness
- div_opdata1_o  out  32  latched dividend
- div_opdata2_o  out  32  latched divisor
- stall_o  out  1  hold pipeline (combinational)
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- whilo_o  out  1  HI/LO write strobe, one cycle
- dbz_o  out  1  divide-by-zero flag, qualifies whilo_o
- err_o  out  1  sticky watchdog error

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; all registered outputs 0; watchdog and drain counters 0; err_o cleared.
  - stall_o forced 0 while rst==0.
- States: IDLE, WAIT, DONE, DRAIN.
- IDLE:
  - stall_o = inst_valid_i & ~flush_i.
  - If inst_valid_i & ~flush_i: latch op1_i/op2_i/signed_i into div_opdata*/div_signed_o; set dbz flag = (op2_i==0); div_start_o<=1; wd<=0; go WAIT.
- WAIT:
  - div_start_o=1; operands held stable for the whole operation (the divider re-reads them for sign fix-up).
  - stall_o = ~div_ready_i | flush_i.
  - Priority: flush_i > div_ready_i > watchdog.
  - flush_i: div_annul_o<=1 for exactly one cycle; div_start_o<=0; no write; go DRAIN.
  - div_ready_i: hi_o<=div_result_i[63:32]; lo_o<=div_result_i[31:0]; whilo_o<=1; dbz_o<=latched flag; div_start_o<=0; go DONE.
  - wd==TIMEOUT-1 without ready: err_o<=1 (sticky until reset); div_annul_o pulse; div_start_o<=0; go DRAIN.
  - Otherwise wd<=wd+1.
- DONE:
  - whilo_o=1 (and dbz_o if set) for this cycle only; stall_o=0.
  - inst_valid_i here is the completing instruction and is ignored.
  - div_start_o=0, which returns the divider to free.
  - Next: IDLE; whilo_o/dbz_o cleared; hi_o/lo_o hold value.
- DRAIN:
  - div_start_o=0; div_annul_o=0 after its first cycle.
  - stall_o = inst_valid_i.
  - Counts DRAIN_CYCLES cycles, then IDLE.
  - A request arriving during DRAIN is accepted only from IDLE.
- Latency: ready seen at cycle R → whilo_o at R+1; new request earliest at R+2 (IDLE).
- Flush in IDLE or DONE: no action beyond suppressing acceptance in IDLE.
- Flush and ready in the same WAIT cycle: flush wins, result discarded.
- Divide by zero: divider returns 0; hi_o=lo_o=0, dbz_o=1 with whilo_o.
- div_annul_o is never asserted outside a WAIT exit.
- div_start_o never rises within DRAIN_CYCLES of an annul.
- Reset mid-WAIT: immediate IDLE, start deasserted, no write.

Test Plan:
- DIVU 100/7, divider model ready after 35 cycles → stall_o high 36 cycles; whilo_o one cycle with lo_o=14, hi_o=2, dbz_o=0.
- DIV 0xFFFFFFF9 (-7) / 2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; operands stable on div_opdata* throughout WAIT.
- DIVU 5/0 → whilo_o=1, dbz_o=1, hi_o=lo_o=0.
- flush_i 10 cycles into WAIT → one-cycle div_annul_o, no whilo_o, start_o low 2 cycles; next request's start_o rises no earlier than 3 cycles after flush.
- div_ready_i stuck 0 → err_o=1 after 40 WAIT cycles, annul pulse, controller returns to IDLE and accepts the next divide.
- Two back-to-back divides plus rst pulse mid-WAIT on a third → two strobes with correct results, third aborted, all outputs 0 after reset.
